// File: rtl/inv_shift_rows.sv
// AES-128 InvShiftRows stage: captures a state, rotates row r right by r bytes,
// either one row per cycle (SERIAL=1) or the whole state at once (SERIAL=0).
module inv_shift_rows #(
    parameter bit SERIAL = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enable,
    input  logic [127:0] data_in,
    output logic [127:0] data_shifted,
    output logic         busy,
    output logic         done
);

    localparam int unsigned W = 128;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t         state;
    logic [W-1:0]   work;
    logic [1:0]     row_cnt;

    // Rotate one row right by its row index; byte (r,c) sits at byte slot 15-(4c+r).
    function automatic logic [W-1:0] rot_row(input logic [W-1:0] s, input logic [1:0] row);
        logic [W-1:0] res;
        int unsigned  src;
        res = s;
        for (int unsigned c = 0; c < 4; c++) begin
            src = (c + 4 - 32'(row)) % 4;
            res[8*(15 - (4*c + 32'(row))) +: 8] = s[8*(15 - (4*src + 32'(row))) +: 8];
        end
        return res;
    endfunction

    function automatic logic [W-1:0] inv_all(input logic [W-1:0] s);
        logic [W-1:0] res;
        res = s;
        for (int unsigned r = 1; r < 4; r++) begin
            res = rot_row(res, 2'(r));
        end
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state        <= IDLE;
            work         <= '0;
            row_cnt      <= '0;
            data_shifted <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (enable) begin
                        work    <= data_in;
                        row_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    if (SERIAL) begin
                        // Final row lands directly in the output register.
                        if (row_cnt == 2'd3) begin
                            work         <= rot_row(work, 2'd3);
                            data_shifted <= rot_row(work, 2'd3);
                            row_cnt      <= '0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            state        <= DONE;
                        end else begin
                            work    <= rot_row(work, row_cnt);
                            row_cnt <= row_cnt + 2'd1;
                        end
                    end else begin
                        work         <= inv_all(work);
                        data_shifted <= inv_all(work);
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        state        <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_shift_rows.sv
// Scoreboard bench for inv_shift_rows: one serial and one single-cycle instance.
module tb_inv_shift_rows;

    logic         clk;
    logic         rst;
    logic         en  [2];
    logic [127:0] din [2];
    logic [127:0] dsh [2];
    logic         bsy [2];
    logic         dn  [2];

    logic [127:0] q0[$];
    logic [127:0] q1[$];
    int           done_cnt [2];
    logic         prev_dn  [2];
    int           n_cmp;
    int           n_err;

    localparam logic [127:0] V1 = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] E1 = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] V3 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] E3 = 128'h00ddaa774411eebb885522ffcc996633;

    inv_shift_rows #(.SERIAL(1'b1)) u_ser (
        .clk(clk), .reset_n(rst), .enable(en[0]), .data_in(din[0]),
        .data_shifted(dsh[0]), .busy(bsy[0]), .done(dn[0])
    );

    inv_shift_rows #(.SERIAL(1'b0)) u_par (
        .clk(clk), .reset_n(rst), .enable(en[1]), .data_in(din[1]),
        .data_shifted(dsh[1]), .busy(bsy[1]), .done(dn[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: out(r,c) = in(r,(c-r) mod 4), indexed byte by byte.
    function automatic logic [127:0] model(input logic [127:0] s);
        logic [7:0]   b [16];
        logic [127:0] o;
        for (int k = 0; k < 16; k++) b[k] = s[127-8*k -: 8];
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = b[4*((c-r+4)%4)+r];
        return o;
    endfunction

    task automatic push(input int i, input logic [127:0] e);
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Output monitor: pops the scoreboard on each done pulse.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (dn[i]) begin
                done_cnt[i]++;
                chk($sformatf("done_width%0d", i), 128'(prev_dn[i]), 128'(0));
                if (i == 0) begin
                    if (q0.size() == 0) chk("spurious_done0", 128'(q0.size()), 128'(1));
                    else                chk("data0", dsh[0], q0.pop_front());
                end else begin
                    if (q1.size() == 0) chk("spurious_done1", 128'(q1.size()), 128'(1));
                    else                chk("data1", dsh[1], q1.pop_front());
                end
            end
            prev_dn[i] = dn[i];
        end
    end

    task automatic run(input int i, input logic [127:0] data, input logic [127:0] exp,
                       input bit noisy, input int exp_lat);
        int           cnt;
        int           dc0;
        logic [127:0] prev;
        prev = dsh[i];
        dc0  = done_cnt[i];
        en[i]  = 1'b1;
        din[i] = data;
        push(i, exp);
        @(posedge clk); #1;
        en[i] = noisy;
        if (noisy) din[i] = '1;
        chk("busy_start", 128'(bsy[i]), 128'(1));
        cnt = 0;
        while (cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
            if (dn[i]) break;
            chk("hold_result", dsh[i], prev);
            chk("busy_mid", 128'(bsy[i]), 128'(1));
            if (noisy) din[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        en[i] = 1'b0;
        chk("latency", 128'(cnt), 128'(exp_lat));
        chk("busy_end", 128'(bsy[i]), 128'(0));
        @(posedge clk); #1;
        chk("done_fall", 128'(dn[i]), 128'(0));
        chk("one_pulse", 128'(done_cnt[i] - dc0), 128'(1));
    endtask

    task automatic b2b(input int i, input logic [127:0] va, input logic [127:0] ea,
                       input logic [127:0] vb, input logic [127:0] eb, input int gap);
        int cnt;
        en[i]  = 1'b1;
        din[i] = va;
        push(i, ea);
        cnt = 0;
        while (!dn[i] && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        din[i] = vb;
        push(i, eb);
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (!dn[i] && cnt < 20);
        en[i] = 1'b0;
        chk("b2b_gap", 128'(cnt), 128'(gap));
        @(posedge clk); #1;
        chk("b2b_done_fall", 128'(dn[i]), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] rv;
        int           dc0;
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 2; i++) begin
            en[i] = 1'b0; din[i] = '0; done_cnt[i] = 0; prev_dn[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_data", dsh[i], 128'(0));
            chk("rst_busy", 128'(bsy[i]), 128'(0));
            chk("rst_done", 128'(dn[i]), 128'(0));
        end
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            chk("idle_done", 128'(dn[0] | dn[1]), 128'(0));
            chk("idle_busy", 128'(bsy[0] | bsy[1]), 128'(0));
        end

        run(0, V1, E1, 1'b0, 4);
        run(0, V3, E3, 1'b0, 4);
        run(1, V3, E3, 1'b0, 1);
        run(1, V1, E1, 1'b0, 1);
        run(0, V1, E1, 1'b1, 4);
        run(1, V3, E3, 1'b1, 1);
        for (int k = 0; k < 3; k++) begin
            rv = {$urandom(), $urandom(), $urandom(), $urandom()};
            run(0, rv, model(rv), 1'b0, 4);
            run(1, rv, model(rv), 1'b0, 1);
        end

        b2b(0, V1, E1, V3, E3, 5);
        b2b(1, V1, E1, V3, E3, 2);

        // Abort a serial transform right after row 1 has been processed.
        en[0]  = 1'b1;
        din[0] = V3;
        @(posedge clk); #1;
        en[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_data", dsh[0], 128'(0));
        chk("abort_busy", 128'(bsy[0]), 128'(0));
        chk("abort_done", 128'(dn[0]), 128'(0));
        dc0 = done_cnt[0];
        repeat (6) @(posedge clk);
        #1;
        chk("abort_no_done", 128'(done_cnt[0] - dc0), 128'(0));
        run(0, V1, E1, 1'b0, 4);

        repeat (3) @(posedge clk);
        #1;
        chk("q0_empty", 128'(q0.size()), 128'(0));
        chk("q1_empty", 128'(q1.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
